// File: rtl/mips_pipeline_mem_access.sv
// MEM stage of the pipelined MIPS core: byte/half/word loads and stores over a
// req/ack data-memory port, registering the MEM/WB record with backpressure.
module mips_pipeline_mem_access #(
  parameter int ADDR_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_aluResult,
  input  logic [31:0]       in_storeData,
  input  logic              in_memRead,
  input  logic              in_memWrite,
  input  logic [1:0]        in_memSize,
  input  logic              in_memSigned,
  input  logic              in_regWrite,
  input  logic [REG_W-1:0]  in_regDest,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic              out_regWrite,
  output logic [REG_W-1:0]  out_regDest,
  output logic              out_fault
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t             r_state, w_state_nxt;
  logic               r_mem_req, r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [3:0]         r_mem_be;
  logic [31:0]        r_mem_wdata;
  logic               r_out_valid, r_out_regWrite, r_out_fault;
  logic [31:0]        r_out_result;
  logic [REG_W-1:0]   r_out_regDest;
  logic [1:0]         r_pend_size, r_pend_off;
  logic               r_pend_signed, r_pend_load, r_pend_regWrite;
  logic [31:0]        r_pend_alu;
  logic [REG_W-1:0]   r_pend_regDest;

  logic w_take, w_is_mem, w_misalign, w_start, w_pass, w_done, w_store;

  function automatic logic [3:0] f_byte_en(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    return 4'b0001 << off;
      2'd1:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] f_store_data(input logic [1:0] size, input logic [31:0] sd);
    case (size)
      2'd0:    return {4{sd[7:0]}};
      2'd1:    return {2{sd[15:0]}};
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] f_load_data(input logic [1:0] size, input logic sgn,
                                              input logic [1:0] off, input logic [31:0] rdata);
    logic [31:0] lane;
    lane = rdata >> {off, 3'b000};
    case (size)
      2'd0:    return {{24{sgn & lane[7]}}, lane[7:0]};
      2'd1:    return {{16{sgn & lane[15]}}, lane[15:0]};
      default: return rdata;
    endcase
  endfunction

  assign in_ready   = (r_state == S_IDLE) && (!r_out_valid || out_ready);
  assign w_take     = in_valid && in_ready;
  assign w_is_mem   = in_memRead | in_memWrite;
  // Size 3 is illegal and handled as a word, so size[1] covers both.
  assign w_misalign = w_is_mem && (((in_memSize == 2'd1) && in_aluResult[0]) ||
                                   (in_memSize[1] && (in_aluResult[1:0] != 2'b00)));
  assign w_start    = w_take && w_is_mem && !w_misalign;
  assign w_pass     = w_take && !(w_is_mem && !w_misalign);
  assign w_done     = (r_state == S_WAIT) && mem_ack;
  assign w_store    = in_memWrite;

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_WAIT;
      S_WAIT:  if (mem_ack) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Memory request: launched on accept, held stable until acknowledged.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_mem_req       <= 1'b0;
      r_mem_we        <= 1'b0;
      r_mem_addr      <= '0;
      r_mem_be        <= 4'b0000;
      r_mem_wdata     <= '0;
      r_pend_size     <= '0;
      r_pend_off      <= '0;
      r_pend_signed   <= 1'b0;
      r_pend_load     <= 1'b0;
      r_pend_regWrite <= 1'b0;
      r_pend_alu      <= '0;
      r_pend_regDest  <= '0;
    end else if (w_start) begin
      r_mem_req       <= 1'b1;
      r_mem_we        <= w_store;
      r_mem_addr      <= {in_aluResult[ADDR_W-1:2], 2'b00};
      r_mem_be        <= w_store ? f_byte_en(in_memSize, in_aluResult[1:0]) : 4'b0000;
      r_mem_wdata     <= f_store_data(in_memSize, in_storeData);
      r_pend_size     <= in_memSize;
      r_pend_off      <= in_aluResult[1:0];
      r_pend_signed   <= in_memSigned;
      r_pend_load     <= !w_store;
      r_pend_regWrite <= in_regWrite;
      r_pend_alu      <= in_aluResult;
      r_pend_regDest  <= in_regDest;
    end else if (w_done) begin
      r_mem_req <= 1'b0;
      r_mem_we  <= 1'b0;
      r_mem_be  <= 4'b0000;
    end
  end

  // MEM/WB output register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_valid    <= 1'b0;
      r_out_result   <= '0;
      r_out_regWrite <= 1'b0;
      r_out_regDest  <= '0;
      r_out_fault    <= 1'b0;
    end else if (w_pass) begin
      r_out_valid    <= 1'b1;
      r_out_result   <= in_aluResult;
      r_out_regWrite <= in_regWrite && !w_misalign;
      r_out_regDest  <= in_regDest;
      r_out_fault    <= w_misalign;
    end else if (w_done) begin
      r_out_valid    <= 1'b1;
      r_out_result   <= r_pend_load ? f_load_data(r_pend_size, r_pend_signed, r_pend_off, mem_rdata)
                                    : r_pend_alu;
      r_out_regWrite <= r_pend_regWrite;
      r_out_regDest  <= r_pend_regDest;
      r_out_fault    <= 1'b0;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_be       = r_mem_be;
  assign mem_wdata    = r_mem_wdata;
  assign out_valid    = r_out_valid;
  assign out_result   = r_out_result;
  assign out_regWrite = r_out_regWrite;
  assign out_regDest  = r_out_regDest;
  assign out_fault    = r_out_fault;

endmodule

// File: tb/tb_mips_pipeline_mem_access.sv
// Directed bench for mips_pipeline_mem_access with immediate-assertion checks.
module tb_mips_pipeline_mem_access;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_aluResult, in_storeData;
  logic        in_memRead, in_memWrite, in_memSigned, in_regWrite;
  logic [1:0]  in_memSize;
  logic [4:0]  in_regDest;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        out_valid, out_ready, out_regWrite, out_fault;
  logic [31:0] out_result;
  logic [4:0]  out_regDest;

  int tests = 0;
  int failed = 0;

  mips_pipeline_mem_access #(.ADDR_W(32), .REG_W(5)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_aluResult(in_aluResult), .in_storeData(in_storeData),
    .in_memRead(in_memRead), .in_memWrite(in_memWrite),
    .in_memSize(in_memSize), .in_memSigned(in_memSigned),
    .in_regWrite(in_regWrite), .in_regDest(in_regDest),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_regWrite(out_regWrite),
    .out_regDest(out_regDest), .out_fault(out_fault)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] alu, input logic [31:0] sd, input logic rd,
                       input logic wr, input logic [1:0] sz, input logic sgn,
                       input logic rw, input logic [4:0] dst);
    in_valid = 1'b1; in_aluResult = alu; in_storeData = sd; in_memRead = rd;
    in_memWrite = wr; in_memSize = sz; in_memSigned = sgn; in_regWrite = rw; in_regDest = dst;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_aluResult = '0; in_storeData = '0;
    in_memRead = 1'b0; in_memWrite = 1'b0; in_memSize = 2'd0; in_memSigned = 1'b0;
    in_regWrite = 1'b0; in_regDest = '0; mem_ack = 1'b0; mem_rdata = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    chk("rst_out_fault", {31'b0, out_fault}, 32'd0);
    chk("rst_out_regWrite", {31'b0, out_regWrite}, 32'd0);
    chk("rst_out_result", out_result, 32'd0);
    reset = 1'b0;
    tick();

    // Reset in the middle of a WAIT, then a late ack.
    drive(32'h0000_0100, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd3);
    tick();
    in_valid = 1'b0;
    chk("midwait_req", {31'b0, mem_req}, 32'd1);
    chk("midwait_in_ready", {31'b0, in_ready}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hAAAA_5555;
    tick();
    mem_ack = 1'b0;
    chk("lateack_req", {31'b0, mem_req}, 32'd0);
    chk("lateack_out_valid", {31'b0, out_valid}, 32'd0);
    chk("lateack_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("lateack_out_valid2", {31'b0, out_valid}, 32'd0);

    // Back-to-back non-memory records.
    drive(32'h11, 32'h0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 5'd5);
    tick();
    chk("b2b_v0", {31'b0, out_valid}, 32'd1);
    chk("b2b_r0", out_result, 32'h11);
    chk("b2b_dst0", {27'b0, out_regDest}, 32'd5);
    chk("b2b_rw0", {31'b0, out_regWrite}, 32'd1);
    in_aluResult = 32'h22;
    tick();
    chk("b2b_r1", out_result, 32'h22);
    chk("b2b_v1", {31'b0, out_valid}, 32'd1);
    in_aluResult = 32'h33;
    tick();
    chk("b2b_r2", out_result, 32'h33);
    in_valid = 1'b0;
    tick();
    chk("b2b_drain", {31'b0, out_valid}, 32'd0);

    // Signed byte load at offset 3.
    drive(32'h0000_1003, 32'h0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 5'd7);
    tick();
    in_valid = 1'b0;
    chk("lb_req", {31'b0, mem_req}, 32'd1);
    chk("lb_we", {31'b0, mem_we}, 32'd0);
    chk("lb_addr", mem_addr, 32'h0000_1000);
    chk("lb_be", {28'b0, mem_be}, 32'd0);
    chk("lb_no_out", {31'b0, out_valid}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
    tick();
    mem_ack = 1'b0;
    chk("lb_req_drop", {31'b0, mem_req}, 32'd0);
    chk("lb_out_valid", {31'b0, out_valid}, 32'd1);
    chk("lb_result", out_result, 32'hFFFF_FF80);
    chk("lb_regWrite", {31'b0, out_regWrite}, 32'd1);
    chk("lb_dst", {27'b0, out_regDest}, 32'd7);

    // Same load, zero-extended; accepted while the previous result drains.
    drive(32'h0000_1003, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 5'd7);
    tick();
    in_valid = 1'b0;
    chk("lbu_req", {31'b0, mem_req}, 32'd1);
    chk("lbu_drained", {31'b0, out_valid}, 32'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("lbu_result", out_result, 32'h0000_0080);
    tick();

    // Half store at offset 2 with three wait cycles before ack.
    drive(32'h0000_2002, 32'hDEAD_BEEF, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 5'd0);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("sh_req", {31'b0, mem_req}, 32'd1);
      chk("sh_we", {31'b0, mem_we}, 32'd1);
      chk("sh_addr", mem_addr, 32'h0000_2000);
      chk("sh_be", {28'b0, mem_be}, 32'hC);
      chk("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
      chk("sh_in_ready", {31'b0, in_ready}, 32'd0);
      chk("sh_no_out", {31'b0, out_valid}, 32'd0);
      if (i == 3) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    chk("sh_out_valid", {31'b0, out_valid}, 32'd1);
    chk("sh_req_drop", {31'b0, mem_req}, 32'd0);
    chk("sh_result", out_result, 32'h0000_2002);
    chk("sh_regWrite", {31'b0, out_regWrite}, 32'd0);
    tick();

    // Misaligned word load faults without a memory request.
    drive(32'h0000_3001, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 5'd9);
    tick();
    in_valid = 1'b0;
    chk("mis_req", {31'b0, mem_req}, 32'd0);
    chk("mis_out_valid", {31'b0, out_valid}, 32'd1);
    chk("mis_fault", {31'b0, out_fault}, 32'd1);
    chk("mis_regWrite", {31'b0, out_regWrite}, 32'd0);
    chk("mis_result", out_result, 32'h0000_3001);
    tick();
    chk("mis_drain", {31'b0, out_valid}, 32'd0);

    // Backpressure: result held while WB stalls, next record waits.
    out_ready = 1'b0;
    drive(32'h55, 32'h0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b1, 5'd4);
    tick();
    chk("bp_first", out_result, 32'h55);
    chk("bp_fault_clear", {31'b0, out_fault}, 32'd0);
    in_aluResult = 32'h66; in_regDest = 5'd6;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_hold_result", out_result, 32'h55);
      chk("bp_hold_dst", {27'b0, out_regDest}, 32'd4);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_next_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_next_result", out_result, 32'h66);
    chk("bp_next_dst", {27'b0, out_regDest}, 32'd6);
    tick();
    chk("bp_drain", {31'b0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
